sipo_rx: RTL and testbench

Serial-in parallel-out receiver that sits directly downstream of the PISO serializer. It consumes the serializer's 1-bit stream and reassembles WIDTH-bit words. Completed words go into a one-deep output holding register with a valid/ready handshake, so the next frame can shift in while the consumer drains the previous word. It flags lost words (overrun) and signals frame completion with a one-cycle done pulse.

---
 rtl/sipo_rx_if.sv | 27 ++
 rtl/sipo_rx.sv | 169 ++++++++++++++++
 tb/tb_sipo_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// sipo_rx_if: serial input, parallel output handshake and status bundle for sipo_rx.
// The master drives the serial stream and consumes words; the slave is the receiver.
interface sipo_rx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sin;
  logic             sin_en;
  logic             pout_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             done;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, sin, sin_en, pout_ready, ovr_clr,
    input  pout, pout_valid, done, busy, overrun, parity_err
  );

  modport slave (
    input  start, sin, sin_en, pout_ready, ovr_clr,
    output pout, pout_valid, done, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver with a one-deep holding register,
// valid/ready drain, sticky overrun and a one-cycle done pulse per frame.
// Optional macro SIPO_PARITY_EN appends an even-parity bit to every frame.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | capturing data bits on sin_en
// S_PAR   | waiting for the parity bit (SIPO_PARITY_EN only)
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input logic     clk,
  input logic     rst,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_idx;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_d;
  logic [WIDTH-1:0] w_shift_cap;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_done;
  logic             r_overrun;
  logic             w_complete;
  logic             w_write;
  logic             w_drop;
`ifdef SIPO_PARITY_EN
  logic             r_parity_err;
  logic             w_par;
`endif

  // Bit position for the current capture follows the configured bit order.
  assign w_idx = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - r_bit_cnt) : r_bit_cnt;

  // Shift register image with the incoming bit merged in.
  always_comb begin
    w_shift_cap = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_idx == CW'(i)) w_shift_cap[i] = bus.sin;
    end
  end

  // Next-state, counter and completion decode; start always wins and restarts a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_d   = r_shift;
    w_complete  = 1'b0;
    w_word      = w_shift_cap;
`ifdef SIPO_PARITY_EN
    w_par       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_d   = '0;
        end
      end
      S_SHIFT: begin
        if (bus.start) begin
          w_cnt_nxt = '0;
          w_shift_d = '0;
        end else if (bus.sin_en) begin
          w_shift_d = w_shift_cap;
          if (r_bit_cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            w_state_nxt = S_PAR;
            w_cnt_nxt   = CW'(WIDTH);
`else
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      S_PAR: begin
        if (bus.start) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_d   = '0;
        end else if (bus.sin_en) begin
          w_complete  = 1'b1;
          w_word      = r_shift;
          w_par       = (^r_shift) ^ bus.sin;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_write = w_complete && (!r_pout_valid || bus.pout_ready);
  assign w_drop  = w_complete && r_pout_valid && !bus.pout_ready;

  // State, shift register and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_d;
    end
  end

  // Holding register, handshake, done pulse and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_write) begin
        r_pout       <= w_word;
        r_pout_valid <= 1'b1;
      end else if (r_pout_valid && bus.pout_ready) begin
        r_pout_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
      else if (bus.ovr_clr) r_overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity result tracks the word held in pout; dropped words leave it alone.
  always_ff @(posedge clk) begin
    if (rst) r_parity_err <= 1'b0;
    else if (w_write) r_parity_err <= w_par;
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.pout       = r_pout;
  assign bus.pout_valid = r_pout_valid;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: scoreboard bench for sipo_rx, LSB-first and MSB-first instances
// driven by the same stream; expected words are queued at stimulus time and
// popped by a monitor on every pout handshake.
module tb_sipo_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  sipo_rx_if #(.WIDTH(4)) if0 ();
  sipo_rx_if #(.WIDTH(4)) if1 ();

  assign if1.start      = if0.start;
  assign if1.sin        = if0.sin;
  assign if1.sin_en     = if0.sin_en;
  assign if1.pout_ready = if0.pout_ready;
  assign if1.ovr_clr    = if0.ovr_clr;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(0)) u_dut   (.clk(clk), .rst(rst), .bus(if0.slave));
  sipo_rx #(.WIDTH(4), .MSB_FIRST(1)) u_dut_m (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is compared against the head of its scoreboard.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst) begin
      if (if0.done) done_cnt++;
      if (if0.pout_valid && if0.pout_ready) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL sb_lsb_unexpected actual=%0h required=none", {if0.parity_err, if0.pout});
        end else begin
          e = q0.pop_front();
          if ({if0.parity_err, if0.pout} !== e) begin
            failures++;
            $display("FAIL sb_lsb_word actual=%0h required=%0h", {if0.parity_err, if0.pout}, e);
          end
        end
      end
      if (if1.pout_valid && if1.pout_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL sb_msb_unexpected actual=%0h required=none", {if1.parity_err, if1.pout});
        end else begin
          e = q1.pop_front();
          if ({if1.parity_err, if1.pout} !== e) begin
            failures++;
            $display("FAIL sb_msb_word actual=%0h required=%0h", {if1.parity_err, if1.pout}, e);
          end
        end
      end
    end
  end

  // data[0] is sent first; e0/e1 are {parity_err, pout} for the LSB/MSB-first instances.
  task automatic send_frame(input logic [3:0] data, input logic par, input int gap,
                            input bit push, input logic [4:0] e0, input logic [4:0] e1);
    if (push) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    chk("busy_after_start", if0.busy, 1);
    for (int i = 0; i < 4; i++) begin
      if0.sin    = data[i];
      if0.sin_en = 1'b1;
      step();
      if0.sin_en = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          step();
          chk("busy_in_gap", if0.busy, 1);
        end
      end
    end
`ifdef SIPO_PARITY_EN
    chk("no_done_before_parity", if0.done, 0);
    if0.sin    = par;
    if0.sin_en = 1'b1;
    step();
    if0.sin_en = 1'b0;
`else
    if (par) if0.sin = 1'b0;
`endif
    chk("done_pulse", if0.done, 1);
    chk("busy_end", if0.busy, 0);
    step();
    chk("done_one_cycle", if0.done, 0);
  endtask

  initial begin
    int d0;
    if0.start = 0; if0.sin = 0; if0.sin_en = 0; if0.pout_ready = 0; if0.ovr_clr = 0;
    repeat (2) step();
    chk("rst_pout", if0.pout, 0);
    chk("rst_valid", if0.pout_valid, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_overrun", if0.overrun, 0);
    chk("rst_parity", if0.parity_err, 0);
    rst = 1'b0;
    step();

    // Basic receive
    if0.pout_ready = 1'b1;
    d0 = done_cnt;
    send_frame(4'b1011, 1'b1, 0, 1'b1, 5'b0_1011, 5'b0_1101);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_overrun", if0.overrun, 0);

    // Gapped input
    d0 = done_cnt;
    send_frame(4'b1011, 1'b1, 2, 1'b1, 5'b0_1011, 5'b0_1101);
    chk("t2_done_count", done_cnt - d0, 1);

    // Backpressure and overrun
    if0.pout_ready = 1'b0;
    d0 = done_cnt;
    send_frame(4'b1011, 1'b1, 0, 1'b1, 5'b0_1011, 5'b0_1101);
    send_frame(4'b0101, 1'b0, 0, 1'b0, 5'b0, 5'b0);
    chk("t3_done_count", done_cnt - d0, 2);
    chk("t3_pout_held", if0.pout, 4'b1011);
    chk("t3_valid_held", if0.pout_valid, 1);
    chk("t3_overrun", if0.overrun, 1);
    chk("t3_overrun_msb", if1.overrun, 1);
    if0.pout_ready = 1'b1;
    step();
    chk("t3_valid_drained", if0.pout_valid, 0);
    chk("t3_pout_kept", if0.pout, 4'b1011);
    chk("t3_overrun_sticky", if0.overrun, 1);
    if0.ovr_clr = 1'b1;
    step();
    if0.ovr_clr = 1'b0;
    chk("t3_overrun_clr", if0.overrun, 0);

    // Restart mid-frame
    d0 = done_cnt;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    if0.sin = 1'b1; if0.sin_en = 1'b1; step();
    if0.sin = 1'b0; step();
    if0.sin_en = 1'b0;
    send_frame(4'b0110, 1'b0, 0, 1'b1, 5'b0_0110, 5'b0_0110);
    chk("t4_done_count", done_cnt - d0, 1);

    // Reset mid-frame
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    if0.sin = 1'b1; if0.sin_en = 1'b1; step(); step();
    if0.sin_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", if0.busy, 0);
    chk("t5_pout", if0.pout, 0);
    chk("t5_valid", if0.pout_valid, 0);
    chk("t5_done", if0.done, 0);
    chk("t5_overrun", if0.overrun, 0);
    d0 = done_cnt;
    send_frame(4'b1001, 1'b0, 0, 1'b1, 5'b0_1001, 5'b0_1001);
    chk("t5_done_count", done_cnt - d0, 1);

`ifdef SIPO_PARITY_EN
    d0 = done_cnt;
    send_frame(4'b1011, 1'b1, 0, 1'b1, 5'b0_1011, 5'b0_1101);
    send_frame(4'b1011, 1'b0, 1, 1'b1, 5'b1_1011, 5'b1_1101);
    chk("t6_done_count", done_cnt - d0, 2);
    chk("t6_parity_err", if0.parity_err, 1);
`endif

    repeat (3) step();
    chk("sb_lsb_empty", q0.size(), 0);
    chk("sb_msb_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
